// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder: accepts one load/store, waits WAIT_STATES cycles, then responds.
// Optional MISALIGN_CHECK_EN turns misaligned half/word accesses and maskmode 11 into error responses.
module data_mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_maskmode,
    input  logic                  req_sext,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam bit ZERO_WAIT = (WAIT_STATES == 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state_reg, state_next;
    logic [3:0]              cnt_reg;
    logic                    write_reg;
    logic [ADDR_WIDTH+1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [1:0]              mode_reg;
    logic                    sext_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg;
    logic                    err_reg;

    logic                    op_write;
    logic [ADDR_WIDTH+1:0]   op_addr;
    logic [DATA_WIDTH-1:0]   op_wdata;
    logic [1:0]              op_mode;
    logic                    op_sext;
    logic                    op_err;
    logic                    accept;
    logic                    commit;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [1:0]              lane;
    logic [3:0]              be;
    logic [DATA_WIDTH-1:0]   wlanes;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;
    logic [DATA_WIDTH-1:0]   load_val;
    logic                    unused_addr;

    assign unused_addr = ^req_addr[DATA_WIDTH-1:ADDR_WIDTH+2];

    assign accept     = (state_reg == IDLE) && req_valid;
    assign commit     = (accept && ZERO_WAIT) || ((state_reg == WAIT) && (cnt_reg == 4'd0));
    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = rdata_reg;
    assign resp_err   = err_reg;

    // With zero wait states the commit happens on the accept edge, so use the live request.
    always_comb begin
        op_write = write_reg;
        op_addr  = addr_reg;
        op_wdata = wdata_reg;
        op_mode  = mode_reg;
        op_sext  = sext_reg;
        if (state_reg == IDLE) begin
            op_write = req_write;
            op_addr  = req_addr[ADDR_WIDTH+1:0];
            op_wdata = req_wdata;
            op_mode  = req_maskmode;
            op_sext  = req_sext;
        end
    end

`ifdef MISALIGN_CHECK_EN
    assign op_err = ((op_mode == 2'b01) && op_addr[0]) ||
                    ((op_mode == 2'b10) && (op_addr[1:0] != 2'b00)) ||
                    (op_mode == 2'b11);
`else
    assign op_err = 1'b0;
`endif

    assign idx  = op_addr[ADDR_WIDTH+1:2];
    assign lane = op_addr[1:0];

    always_comb begin
        be     = 4'hF;
        wlanes = op_wdata;
        case (op_mode)
            2'b00: begin
                be     = 4'b0001 << lane;
                wlanes = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                be     = lane[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{op_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // One byte-wide array per lane keeps store masking a plain per-lane write enable.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [0:DEPTH-1];
            always_ff @(posedge clk) begin
                if (commit && op_write && !op_err && be[gi])
                    mem[idx] <= wlanes[gi*8 +: 8];
            end
            assign rd_word[gi*8 +: 8] = mem[idx];
        end
    endgenerate

    always_comb begin
        case (lane)
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = rd_word;
        case (op_mode)
            2'b00:   load_val = {{24{op_sext & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{op_sext & half_sel[15]}}, half_sel};
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = ZERO_WAIT ? RESP : WAIT;
            WAIT:    if (cnt_reg == 4'd0) state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            write_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            mode_reg  <= 2'b00;
            sext_reg  <= 1'b0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                write_reg <= req_write;
                addr_reg  <= req_addr[ADDR_WIDTH+1:0];
                wdata_reg <= req_wdata;
                mode_reg  <= req_maskmode;
                sext_reg  <= req_sext;
                cnt_reg   <= ZERO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);
            end else if ((state_reg == WAIT) && (cnt_reg != 4'd0)) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            if (commit) begin
                rdata_reg <= (op_write || op_err) ? '0 : load_val;
                err_reg   <= op_err;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table of loads/stores plus hand-written
// backpressure and reset-in-flight sequences. Honours MISALIGN_CHECK_EN when defined.
module tb_data_mem_responder;

    localparam int WS = 2;
`ifdef MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_maskmode = 2'b10;
    logic        req_sext = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_maskmode(req_maskmode),
        .req_sext(req_sext),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  m;
        logic        s;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] m, input logic s,
                       input logic [31:0] er, input logic ee);
        vec_t v;
        v = '{w: w, a: a, d: d, m: m, s: s, exp_rd: er, exp_err: ee};
        vecs.push_back(v);
    endtask

    // Present a request, get it accepted, and wait (bounded) for resp_valid.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] m, input logic s, output int lat);
        @(negedge clk);
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_write = w; req_addr = a; req_wdata = d; req_maskmode = m; req_sext = s;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 40) begin
            bad++;
            $display("FAIL timeout: resp_valid never rose for addr %h", a);
        end
    endtask

    task automatic complete();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] m, input logic s,
                        output logic [31:0] rd, output logic e, output int lat);
        issue(w, a, d, m, s, lat);
        rd = resp_rdata;
        e  = resp_err;
        complete();
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;

        // stores have exp_rd 0; word=10, half=01, byte=00, reserved=11
        add(1, 32'h10,  32'hDEADBEEF, 2'b10, 0, 32'h0, 0);
        add(0, 32'h10,  32'h0,        2'b10, 0, 32'hDEADBEEF, 0);
        add(1, 32'h10,  32'h11223344, 2'b10, 0, 32'h0, 0);
        add(1, 32'h13,  32'h00000080, 2'b00, 0, 32'h0, 0);
        add(0, 32'h10,  32'h0,        2'b10, 0, 32'h80223344, 0);
        add(0, 32'h13,  32'h0,        2'b00, 1, 32'hFFFFFF80, 0);
        add(0, 32'h13,  32'h0,        2'b00, 0, 32'h00000080, 0);
        add(0, 32'h12,  32'h0,        2'b01, 1, 32'hFFFF8022, 0);
        add(0, 32'h10,  32'h0,        2'b01, 0, 32'h00003344, 0);
        add(0, 32'h10,  32'h0,        2'b00, 1, 32'h00000044, 0);
        add(0, 32'h11,  32'h0,        2'b00, 0, 32'h00000033, 0);
        add(1, 32'h14,  32'h0,        2'b10, 0, 32'h0, 0);
        add(1, 32'h16,  32'hBEEFCAFE, 2'b01, 0, 32'h0, 0);
        add(0, 32'h14,  32'h0,        2'b10, 1, 32'hCAFE0000, 0);
        add(1, 32'h12,  32'h0000007F, 2'b00, 0, 32'h0, 0);
        add(0, 32'h12,  32'h0,        2'b01, 1, 32'hFFFF807F, 0);
        add(1, 32'h404, 32'hA5A5A5A5, 2'b10, 0, 32'h0, 0);
        add(0, 32'h004, 32'h0,        2'b10, 0, 32'hA5A5A5A5, 0);
        add(0, 32'h10,  32'h0,        2'b11, 0, MIS ? 32'h0 : 32'h807F3344, MIS);
        add(0, 32'h11,  32'h0,        2'b10, 0, MIS ? 32'h0 : 32'h807F3344, MIS);
        add(1, 32'h12,  32'h12345678, 2'b10, 0, 32'h0, MIS);
        add(0, 32'h10,  32'h0,        2'b10, 0, MIS ? 32'h807F3344 : 32'h12345678, 0);
        add(1, 32'h20,  32'h0,        2'b10, 0, 32'h0, 0);
        add(1, 32'h24,  32'h0,        2'b10, 0, 32'h0, 0);

        // reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_req_ready",  {31'b0, req_ready},  32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata,          32'd0);
        chk("rst_resp_err",   {31'b0, resp_err},   32'd0);

        foreach (vecs[i]) begin
            xact(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].m, vecs[i].s, rd, e, lat);
            $display("vec %0d w=%0d addr=%h m=%0d s=%0d rdata=%h err=%0d lat=%0d",
                     i, vecs[i].w, vecs[i].a, vecs[i].m, vecs[i].s, rd, e, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
            chk($sformatf("vec%0d_lat", i), lat, 1 + WS);
        end

        // backpressure: hold resp_ready low for 5 cycles on a load
        issue(0, 32'h004, 32'h0, 2'b10, 0, lat);
        chk("bp_lat", lat, 1 + WS);
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", {31'b0, resp_valid}, 32'd1);
            chk("bp_rdata", resp_rdata, 32'hA5A5A5A5);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        complete();
        chk("bp_idle_ready", {31'b0, req_ready}, 32'd1);
        chk("bp_idle_valid", {31'b0, resp_valid}, 32'd0);
        chk("bp_hold_rdata", resp_rdata, 32'hA5A5A5A5);
        $display("seq backpressure rdata=%h", resp_rdata);

        // reset while in WAIT drops the store to 0x20
        @(negedge clk);
        req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h5; req_maskmode = 2'b10;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("wrst_req_ready",  {31'b0, req_ready},  32'd1);
        chk("wrst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("wrst_resp_rdata", resp_rdata,          32'd0);
        repeat (4) begin
            @(posedge clk); #1;
            chk("wrst_no_resp", {31'b0, resp_valid}, 32'd0);
        end
        xact(0, 32'h20, 32'h0, 2'b10, 0, rd, e, lat);
        $display("seq rst_in_wait load@20 rdata=%h", rd);
        chk("wrst_load", rd, 32'h0);

        // reset coincident with req_valid: request not accepted
        @(negedge clk);
        rst = 1'b1;
        req_write = 1'b1; req_addr = 32'h24; req_wdata = 32'h77; req_maskmode = 2'b10;
        req_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("crst_no_resp", {31'b0, resp_valid}, 32'd0);
        end
        xact(0, 32'h24, 32'h0, 2'b10, 0, rd, e, lat);
        $display("seq rst_with_req load@24 rdata=%h", rd);
        chk("crst_load", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for CPU load/store traffic: accepts one request at a time over a valid/ready handshake, inserts a fixed number of wait states, then returns a response on a second valid/ready channel. It performs byte/halfword/word lane selection, store masking and load sign/zero extension. It replaces the combinational data memory behind the datapath's MEM stage once that stage issues handshaked requests (maskmode/sext encoding unchanged).

## Interface

- DATA_WIDTH, 32, data bus width; only 32 supported
- ADDR_WIDTH, 8, word-index bits; storage = 2^ADDR_WIDTH words
- WAIT_STATES, 2, cycles between accept and response; 0..15 legal

- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low-aligned (byte in [7:0], half in [15:0])
- req_maskmode  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_sext  in  1  loads: 1 sign-extend, 0 zero-extend
- resp_valid  out  1  response present
- resp_ready  in  1  requester accepts response
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  error response (only driven with macro, see Configuration)

## Operation

- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch write/addr/wdata/maskmode/sext; go to WAIT (WAIT_STATES>0) or RESP (WAIT_STATES=0).
- WAIT: req_ready=0; 4-bit counter loads WAIT_STATES-1 on accept, decrements; at 0 go to RESP.
- Commit edge = edge entering RESP: store writes memory, load samples memory into resp_rdata.
- RESP: resp_valid=1, resp_rdata/resp_err held stable; on resp_ready go to IDLE. No request accepted in RESP.
- Word index = addr[ADDR_WIDTH+1:2]; upper address bits ignored (addresses wrap modulo 2^(ADDR_WIDTH+2)).
- Byte: lane addr[1:0]; half: lane addr[1] (bits [15:0] or [31:16]); word: full word.
- Store writes only the selected lane(s); other bytes unchanged.
- Load: selected lane shifted to bit 0, extended to 32 per req_sext; word ignores req_sext.
- Maskmode 11: treated as word.
- Memory contents not affected by rst; initial contents undefined (bench preloads via hierarchical write or $readmemh).

## Timing

- Reset values (after rst edge): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter 0.
- req_ready and resp_valid are decoded from registered state only; no combinational path from req_valid or resp_ready to any output.
- Request accepted in cycle t -> resp_valid first high in cycle t+1+WAIT_STATES.
- Max throughput: one transaction per WAIT_STATES+2 cycles (resp_ready held high).
- Backpressure: resp_ready low holds RESP indefinitely; outputs unchanged.
- rst during WAIT: transaction dropped, store not committed. rst in RESP: response dropped (store already committed).
- rst with req_valid high in same cycle: request not accepted.
- resp_rdata returns to 0 only on rst; otherwise holds last response value outside RESP.

## Configuration

- MISALIGN_CHECK_EN defined: half with addr[0]=1, word with addr[1:0]!=0, or maskmode 11 -> error response: no memory write, resp_rdata=0, resp_err=1, same latency as normal.
- Undefined: resp_err tied 0; low address bits below the access size ignored (half uses addr[1], word uses word index only).

## Test plan

- WAIT_STATES=2: store word 0xDEADBEEF @0x10, load word @0x10 -> resp_rdata=0xDEADBEEF, resp_valid in cycle accept+3 both times.
- Store byte 0x80 @0x13 over word 0x11223344 @0x10 -> word 0x80223344; lb @0x13 -> 0xFFFFFF80; lbu -> 0x00000080; lh sext @0x12 -> 0xFFFF8022.
- Load with resp_ready low 5 cycles -> resp_valid and resp_rdata stable 5 cycles, req_ready=0; IDLE one cycle after resp_ready.
- Store 0x5 @0x20 (old 0x0), rst pulse in WAIT -> outputs at reset values; subsequent load @0x20 -> 0x0.
- ADDR_WIDTH=8: store 0xA5A5A5A5 @0x404 -> load @0x004 returns 0xA5A5A5A5.
- MISALIGN_CHECK_EN: lw @0x11 -> resp_err=1, resp_rdata=0; sw @0x12 -> resp_err=1, memory unchanged; without macro sw @0x12 writes word @0x10.
